// File: rtl/uart_paddle_rx.sv
// Remote paddle receiver: 8N1 deserialiser feeding a 4-byte position packet parser
// (A5h, y[9:8], y[7:0], xor checksum) with range check, gap timeout and link health.
module uart_paddle_rx #(
  parameter int CLKS_PER_BIT = 564,
  parameter int Y_MAX        = 767,
  parameter int Y_RESET      = 384,
  parameter int GAP_CLKS     = 65000,
  parameter int LINK_CLKS    = 6500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [9:0] y_remote,
  output logic       y_valid,
  output logic       link_ok,
  output logic [7:0] err_cnt
);

  localparam int BW = $clog2(CLKS_PER_BIT + 1);
  localparam int GW = $clog2(GAP_CLKS + 1);
  localparam int LW = $clog2(LINK_CLKS + 1);

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;
  typedef enum logic [1:0] {P_HDR, P_HI, P_LO, P_CHK} pkt_state_t;

  bit_state_t    bit_state;
  pkt_state_t    pkt_state;
  logic          rx_meta, rx_sync;
  logic [1:0]    warm;
  logic          armed;
  logic [BW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          byte_stb, frame_err;
  logic          bit_exp;

  logic [1:0]    y_hi;
  logic [7:0]    y_lo;
  logic [9:0]    y_new;
  logic [GW-1:0] gap_cnt;
  logic [LW-1:0] link_cnt;
  logic          gap_exp, pkt_err, accept;

  assign bit_exp = (bit_cnt == BW'(1));

  // A start is only taken once the line has been seen high with real data
  // (warm masks the synchroniser reset values after rst release).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      warm      <= '0;
      armed     <= 1'b0;
      bit_state <= B_IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      warm      <= {warm[0], 1'b1};
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
      if (bit_state != B_IDLE) bit_cnt <= bit_cnt - 1'b1;
      case (bit_state)
        B_IDLE: begin
          if (!armed) begin
            armed <= rx_sync && warm[1];
          end else if (!rx_sync) begin
            armed     <= 1'b0;
            bit_state <= B_START;
            bit_cnt   <= BW'(CLKS_PER_BIT / 2);
          end
        end
        B_START: begin
          if (bit_exp) begin
            if (!rx_sync) begin
              bit_state <= B_DATA;
              bit_cnt   <= BW'(CLKS_PER_BIT);
              bit_idx   <= '0;
            end else begin
              bit_state <= B_IDLE;
            end
          end
        end
        B_DATA: begin
          if (bit_exp) begin
            shift   <= {rx_sync, shift[7:1]};
            bit_cnt <= BW'(CLKS_PER_BIT);
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) bit_state <= B_STOP;
          end
        end
        B_STOP: begin
          if (bit_exp) begin
            bit_state <= B_IDLE;
            if (rx_sync) byte_stb  <= 1'b1;
            else         frame_err <= 1'b1;
          end
        end
        default: bit_state <= B_IDLE;
      endcase
    end
  end

  always_comb begin
    y_new   = {y_hi, y_lo};
    gap_exp = (pkt_state != P_HDR) && (gap_cnt == GW'(GAP_CLKS - 1));
    pkt_err = 1'b0;
    accept  = 1'b0;
    if (frame_err || gap_exp) begin
      pkt_err = 1'b1;
    end else if (byte_stb) begin
      case (pkt_state)
        P_HI:  pkt_err = (shift[7:2] != 6'd0);
        P_CHK: begin
          if (((8'hA5 ^ {6'd0, y_hi} ^ y_lo) != shift) || (int'(y_new) > Y_MAX))
            pkt_err = 1'b1;
          else
            accept = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Gap timeout takes priority; a byte arriving in that same cycle is parsed as if in HDR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_state <= P_HDR;
      y_hi      <= '0;
      y_lo      <= '0;
      gap_cnt   <= '0;
      link_cnt  <= '0;
      y_remote  <= 10'(Y_RESET);
      y_valid   <= 1'b0;
      link_ok   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      y_valid <= 1'b0;

      if (frame_err) begin
        pkt_state <= P_HDR;
      end else if (gap_exp) begin
        pkt_state <= (byte_stb && shift == 8'hA5) ? P_HI : P_HDR;
      end else if (byte_stb) begin
        case (pkt_state)
          P_HDR: if (shift == 8'hA5) pkt_state <= P_HI;
          P_HI: begin
            if (shift[7:2] != 6'd0) begin
              pkt_state <= P_HDR;
            end else begin
              y_hi      <= shift[1:0];
              pkt_state <= P_LO;
            end
          end
          P_LO: begin
            y_lo      <= shift;
            pkt_state <= P_CHK;
          end
          P_CHK: begin
            pkt_state <= P_HDR;
            if (accept) begin
              y_remote <= y_new;
              y_valid  <= 1'b1;
            end
          end
          default: pkt_state <= P_HDR;
        endcase
      end

      if (byte_stb || pkt_state == P_HDR) gap_cnt <= '0;
      else                                gap_cnt <= gap_cnt + 1'b1;

      if (pkt_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;

      if (accept) begin
        link_cnt <= LW'(LINK_CLKS);
        link_ok  <= 1'b1;
      end else if (link_cnt != '0) begin
        link_cnt <= link_cnt - 1'b1;
        if (link_cnt == LW'(1)) link_ok <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_paddle_rx.sv
// Directed bench for uart_paddle_rx: serial packets driven bit by bit, outputs
// compared against hand-computed values.
module tb_uart_paddle_rx;

  localparam int CPB  = 16;
  localparam int GAP  = 1000;
  localparam int LINK = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [9:0] y_remote;
  logic       y_valid;
  logic       link_ok;
  logic [7:0] err_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int vcount = 0;
  int last_v_cyc = 0;
  int byte_start_cyc = 0;

  uart_paddle_rx #(
    .CLKS_PER_BIT(CPB),
    .Y_MAX(767),
    .Y_RESET(384),
    .GAP_CLKS(GAP),
    .LINK_CLKS(LINK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .y_remote(y_remote),
    .y_valid(y_valid),
    .link_ok(link_ok),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (y_valid === 1'b1) begin vcount++; last_v_cyc = cyc; end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    byte_start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b1);
    send_byte(b2, 1'b1);
    send_byte(b3, 1'b1);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    rx  = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (y_remote !== 10'd384) begin errors++; $display("FAIL reset_y: got %0d expected 384", y_remote); end
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", y_valid); end
    checks++; if (link_ok !== 1'b0) begin errors++; $display("FAIL reset_link: got %b expected 0", link_ok); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err: got %0d expected 0", err_cnt); end
    @(negedge clk) rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_valid;
    int v0;
    v0 = vcount;
    send_pkt(8'hA5, 8'h01, 8'h2C, 8'h88);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (vcount !== v0 + 1) begin errors++; $display("FAIL valid_pulses: got %0d expected %0d", vcount - v0, 1); end
    // sync 2 + arm/edge 1 + half bit 8 + 9 bits of 16 + strobe 1
    checks++; if (last_v_cyc - byte_start_cyc !== 156) begin errors++; $display("FAIL valid_latency: got %0d expected 156", last_v_cyc - byte_start_cyc); end
    checks++; if (y_remote !== 10'd300) begin errors++; $display("FAIL valid_y: got %0d expected 300", y_remote); end
    checks++; if (link_ok !== 1'b1) begin errors++; $display("FAIL valid_link: got %b expected 1", link_ok); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL valid_err: got %0d expected 0", err_cnt); end
  endtask

  task automatic test_bad_checksum;
    int v0;
    v0 = vcount;
    send_pkt(8'hA5, 8'h01, 8'h2C, 8'h89);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (vcount !== v0) begin errors++; $display("FAIL chk_pulses: got %0d expected 0", vcount - v0); end
    checks++; if (y_remote !== 10'd300) begin errors++; $display("FAIL chk_y: got %0d expected 300", y_remote); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL chk_err: got %0d expected 1", err_cnt); end
  endtask

  task automatic test_range;
    int v0;
    v0 = vcount;
    send_pkt(8'hA5, 8'h03, 8'h10, 8'hB6);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (vcount !== v0) begin errors++; $display("FAIL range_pulses: got %0d expected 0", vcount - v0); end
    checks++; if (y_remote !== 10'd300) begin errors++; $display("FAIL range_y: got %0d expected 300", y_remote); end
    checks++; if (err_cnt !== 8'd2) begin errors++; $display("FAIL range_err: got %0d expected 2", err_cnt); end
    send_pkt(8'hA5, 8'h02, 8'hFF, 8'h58);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (y_remote !== 10'd767) begin errors++; $display("FAIL ymax_y: got %0d expected 767", y_remote); end
    checks++; if (vcount !== v0 + 1) begin errors++; $display("FAIL ymax_pulses: got %0d expected 1", vcount - v0); end
    checks++; if (err_cnt !== 8'd2) begin errors++; $display("FAIL ymax_err: got %0d expected 2", err_cnt); end
  endtask

  task automatic test_framing;
    int v0;
    send_byte(8'h3C, 1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    checks++; if (err_cnt !== 8'd3) begin errors++; $display("FAIL frame_err: got %0d expected 3", err_cnt); end
    send_pkt(8'hA5, 8'h00, 8'h05, 8'hA0);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (y_remote !== 10'd5) begin errors++; $display("FAIL frame_y: got %0d expected 5", y_remote); end
    v0 = vcount;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checks++; if (err_cnt !== 8'd3) begin errors++; $display("FAIL glitch_err: got %0d expected 3", err_cnt); end
    checks++; if (vcount !== v0) begin errors++; $display("FAIL glitch_pulses: got %0d expected 0", vcount - v0); end
  endtask

  task automatic test_gap;
    int v0;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (800) @(posedge clk);
    #1;
    checks++; if (err_cnt !== 8'd3) begin errors++; $display("FAIL gap_early: got %0d expected 3", err_cnt); end
    repeat (GAP + 1 - 800) @(posedge clk);
    #1;
    checks++; if (err_cnt !== 8'd4) begin errors++; $display("FAIL gap_err: got %0d expected 4", err_cnt); end
    v0 = vcount;
    send_pkt(8'hA5, 8'h00, 8'h00, 8'hA5);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (y_remote !== 10'd0) begin errors++; $display("FAIL gap_y: got %0d expected 0", y_remote); end
    checks++; if (vcount !== v0 + 1) begin errors++; $display("FAIL gap_pulses: got %0d expected 1", vcount - v0); end
    checks++; if (err_cnt !== 8'd4) begin errors++; $display("FAIL gap_err_after: got %0d expected 4", err_cnt); end
  endtask

  task automatic test_link;
    // Accept landed 4 cycles before the previous task's send returned, then 3 waited.
    repeat (1800) @(posedge clk);
    #1;
    checks++; if (link_ok !== 1'b1) begin errors++; $display("FAIL link_hold: got %b expected 1", link_ok); end
    repeat (250) @(posedge clk);
    #1;
    checks++; if (link_ok !== 1'b0) begin errors++; $display("FAIL link_drop: got %b expected 0", link_ok); end
    checks++; if (y_remote !== 10'd0) begin errors++; $display("FAIL link_y_held: got %0d expected 0", y_remote); end
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 250; i++) begin
      send_byte(8'h00, 1'b0);
      send_bit(1'b1);
    end
    checks++; if (err_cnt !== 8'd254) begin errors++; $display("FAIL sat_254: got %0d expected 254", err_cnt); end
    for (int i = 0; i < 20; i++) begin
      send_byte(8'h00, 1'b0);
      send_bit(1'b1);
    end
    checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL sat_255: got %0d expected 255", err_cnt); end
    checks++; if (y_remote !== 10'd0) begin errors++; $display("FAIL sat_y: got %0d expected 0", y_remote); end
  endtask

  task automatic test_reset_mid;
    int v0;
    send_bit(1'b0);
    send_bit(1'b1);
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checks++; if (y_remote !== 10'd384) begin errors++; $display("FAIL rmid_y: got %0d expected 384", y_remote); end
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b expected 0", y_valid); end
    checks++; if (link_ok !== 1'b0) begin errors++; $display("FAIL rmid_link: got %b expected 0", link_ok); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL rmid_err: got %0d expected 0", err_cnt); end
    @(negedge clk) rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL rmid_low_line: got %0d expected 0", err_cnt); end
    rx = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    v0 = vcount;
    send_pkt(8'hA5, 8'h01, 8'h2C, 8'h88);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (y_remote !== 10'd300) begin errors++; $display("FAIL rmid_after_y: got %0d expected 300", y_remote); end
    checks++; if (vcount !== v0 + 1) begin errors++; $display("FAIL rmid_after_pulses: got %0d expected 1", vcount - v0); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL rmid_after_err: got %0d expected 0", err_cnt); end
  endtask

  initial begin
    test_reset;
    test_valid;
    test_bad_checksum;
    test_range;
    test_framing;
    test_gap;
    test_link;
    test_saturate;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_paddle_rx.md
Name: uart_paddle_rx

Overview:
- Receives the opponent's paddle position over the board-to-board UART link (JC rx pin) for two-board play.
- Sits directly upstream of the game logic: deserialises 8N1 bytes, parses 4-byte position packets and validates them.
- Presents a held, range-checked remote paddle Y with an update strobe and link-health status.

Parameters:
- CLKS_PER_BIT, 564, clock cycles per UART bit (65 MHz / 115200); must be >= 8.
- Y_MAX, 767, largest accepted paddle Y; larger values are rejected.
- Y_RESET, 384, y_remote value after reset.
- GAP_CLKS, 65000, maximum idle cycles between bytes inside a packet.
- LINK_CLKS, 6500000, cycles without a valid packet before link_ok drops.

Ports:
- clk  input  1  system clock, 65 MHz
- rst  input  1  asynchronous, active-low reset
- rx  input  1  raw serial input, idle high, asynchronous to clk
- y_remote  output  10  last accepted remote paddle Y
- y_valid  output  1  one-cycle pulse when y_remote is updated
- link_ok  output  1  high while valid packets keep arriving
- err_cnt  output  8  saturating count of rejected bytes/packets

Behaviour:
- Reset values (rst low, asynchronous): y_remote=Y_RESET, y_valid=0, link_ok=0, err_cnt=0; both FSMs in idle/header state; synchroniser flops =1.
- rx passes through a 2-flop synchroniser. All references to rx below mean the synchronised value.
- Bit FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on a falling edge of rx; the bit counter loads CLKS_PER_BIT/2.
  - START: at counter expiry, rx==0 -> DATA with bit counter = CLKS_PER_BIT. rx==1 is a false start -> IDLE, no error.
  - DATA: samples 8 bits LSB first at each expiry, mid-bit.
  - STOP: samples the stop bit mid-bit. rx==1 -> byte strobe the next cycle. rx==0 is a framing error -> byte discarded, err_cnt+1, packet FSM -> HDR. The FSM then returns to IDLE.
  - The FSM waits for rx==1 before it accepts a new start.
- Packet format: A5h, {000000,y[9:8]}, y[7:0], checksum = A5h ^ byte1 ^ byte2.
- Packet FSM states: HDR, HI, LO, CHK. Each state advances on a byte strobe.
  - HDR: A5h -> HI. Any other byte is ignored silently.
  - HI: byte[7:2]!=0 -> error, -> HDR. Otherwise latch the byte and -> LO.
  - LO: latch the byte, -> CHK.
  - CHK: checksum mismatch, or assembled y>Y_MAX -> error, -> HDR. Otherwise accept and -> HDR.
- Accept timing: y_remote updates and y_valid pulses for exactly 1 cycle, on the cycle after the byte strobe. This is 2 cycles after the stop-bit sample.
- Gap timeout: in HI/LO/CHK, if GAP_CLKS cycles pass with no byte strobe -> error, -> HDR. The counter restarts on every strobe.
- link_ok goes to 1 on an accept. A counter reloads on each accept; after LINK_CLKS cycles without an accept, link_ok goes to 0.
- Rejected packets never change y_remote, which holds its last accepted value indefinitely.
- err_cnt saturates at 255. At most one increment per cycle; simultaneous framing and gap errors count once.
- A byte strobe in the same cycle as gap expiry: the timeout wins, and the byte is then evaluated in HDR.
- Reset mid-byte or mid-packet aborts everything immediately. After release the block waits for an idle-high line.

Test Plan:
- CLKS_PER_BIT=16; send A5h,01h,2Ch,88h -> y_valid pulse at stop-sample+2 cycles, y_remote=300, link_ok=1, err_cnt=0.
- Send A5h,01h,2Ch,89h (bad checksum) after a valid y=300 -> no y_valid, y_remote stays 300, err_cnt=1.
- Send A5h,03h,10h,B6h (y=784>767) -> rejected, err_cnt+1. Then A5h,02h,FFh,58h -> y_remote=767.
- Byte with stop bit=0, followed by a valid packet for y=5 -> err_cnt+1, then y_remote=5. A 4-cycle low glitch on idle rx -> no byte, no error.
- Send A5h,00h, then idle for GAP_CLKS+1 -> err_cnt+1. The following packet for y=0 is accepted. With LINK_CLKS=2000, no traffic for 2000 cycles -> link_ok=0.
- Force 300 bad packets -> err_cnt=255 held. Assert rst mid-byte -> all outputs at reset values within the same cycle.
